spi_master: RTL

//  Serial-bus initiator. Generates sclk and active-low cs, shifts a WIDTH-bit word out on

---
 rtl/spi_master.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// SPI mode-0 initiator: drives sclk/cs, shifts a WIDTH-bit word out on mosi MSB-first,
// and captures WIDTH bits from miso on the sclk rising edges.
module spi_master #(
  parameter int unsigned WIDTH  = 8,  // bits per transaction, >= 2
  parameter int unsigned CLKDIV = 4   // clk cycles per sclk half-period, >= 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] txData,
  input  logic             miso,
  output logic             sclk,
  output logic             mosi,
  output logic             cs,
  output logic [WIDTH-1:0] rxData,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DivW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [DivW-1:0] DivLast = DivW'(CLKDIV - 1);
  localparam logic [CntW-1:0] BitLast = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow,
    StFinish
  } spiState;

  spiState          stateQ, stateD;
  logic [DivW-1:0]  divcntQ, divcntD;
  logic [CntW-1:0]  bitcntQ, bitcntD;
  logic [WIDTH-1:0] shregQ, shregD;
  logic [WIDTH-1:0] rxDataQ, rxDataD;
  logic             sampleQ, sampleD;
  logic             finHoldQ, finHoldD;
  logic             sclkQ, sclkD;
  logic             mosiQ, mosiD;
  logic             csQ, csD;
  logic             busyQ, busyD;
  logic             doneQ, doneD;

  logic             tick;

  // A phase tick closes every CLKDIV-cycle half-period of sclk.
  assign tick = (divcntQ == DivLast);

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ   <= StIdle;
      divcntQ  <= '0;
      bitcntQ  <= '0;
      shregQ   <= '0;
      rxDataQ  <= '0;
      sampleQ  <= 1'b0;
      finHoldQ <= 1'b0;
      sclkQ    <= 1'b0;
      mosiQ    <= 1'b0;
      csQ      <= 1'b1;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      divcntQ  <= divcntD;
      bitcntQ  <= bitcntD;
      shregQ   <= shregD;
      rxDataQ  <= rxDataD;
      sampleQ  <= sampleD;
      finHoldQ <= finHoldD;
      sclkQ    <= sclkD;
      mosiQ    <= mosiD;
      csQ      <= csD;
      busyQ    <= busyD;
      doneQ    <= doneD;
    end
  end

  // Next-state logic: sequencing of setup, sclk high/low phases and the cs hold.
  always_comb begin
    stateD   = stateQ;
    bitcntD  = bitcntQ;
    shregD   = shregQ;
    rxDataD  = rxDataQ;
    sampleD  = sampleQ;
    finHoldD = finHoldQ;
    sclkD    = sclkQ;
    mosiD    = mosiQ;
    csD      = csQ;
    busyD    = busyQ;
    doneD    = 1'b0;

    // Divider free-runs while a transfer is active and restarts at zero from idle,
    // so every transfer has the same phase alignment.
    if (stateQ == StIdle) begin
      divcntD = '0;
    end else if (tick) begin
      divcntD = '0;
    end else begin
      divcntD = divcntQ + DivW'(1);
    end

    unique case (stateQ)
      StIdle: begin
        if (start) begin
          shregD  = txData;
          csD     = 1'b0;
          busyD   = 1'b1;
          mosiD   = txData[WIDTH-1];
          bitcntD = '0;
          stateD  = StSetup;
        end
      end

      // First bit is already on mosi; wait one half-period before the first rise.
      StSetup: begin
        sclkD = 1'b0;
        if (tick) begin
          sclkD   = 1'b1;
          sampleD = miso;
          stateD  = StHigh;
        end
      end

      // Falling edge: commit the sampled bit and present the next mosi bit.
      StHigh: begin
        if (tick) begin
          sclkD   = 1'b0;
          shregD  = {shregQ[WIDTH-2:0], sampleQ};
          bitcntD = bitcntQ + CntW'(1);
          if (bitcntQ == BitLast) begin
            finHoldD = 1'b0;
            stateD   = StFinish;
          end else begin
            mosiD  = shregQ[WIDTH-2];
            stateD = StLow;
          end
        end
      end

      StLow: begin
        if (tick) begin
          sclkD   = 1'b1;
          sampleD = miso;
          stateD  = StHigh;
        end
      end

      // cs stays low with sclk idle for a full sclk period after the last fall.
      StFinish: begin
        if (tick) begin
          if (!finHoldQ) begin
            finHoldD = 1'b1;
          end else begin
            csD     = 1'b1;
            rxDataD = shregQ;
            doneD   = 1'b1;
            busyD   = 1'b0;
            mosiD   = 1'b0;
            stateD  = StIdle;
          end
        end
      end

      default: begin
        stateD = StIdle;
      end
    endcase
  end

  assign sclk   = sclkQ;
  assign mosi   = mosiQ;
  assign cs     = csQ;
  assign rxData = rxDataQ;
  assign busy   = busyQ;
  assign done   = doneQ;

endmodule
